// File: rtl/dly_deglitch_filter.sv
// Synchroniser plus level qualifier for a delay-chain output: Z follows I only after
// FILT_CYCLES stable samples. The optional event counter is built when DLY_DEGLITCH_EVT_CNT_EN is defined.
module dly_deglitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       I,
  output logic       Z,
  output logic       RISE,
  output logic       FALL,
  output logic       BUSY,
  output logic [7:0] EVT_CNT
);
  typedef enum logic [1:0] {LO, QRISE, HI, QFALL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("dly_deglitch_filter: SYNC_STAGES must be 2..4");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
    $error("dly_deglitch_filter: FILT_CYCLES must be 1..255");
  end
  if (FILT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("dly_deglitch_filter: FILT_CYCLES must be < 2**CNT_W");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   z_nxt, rise_nxt, fall_nxt, busy_nxt;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], I};
  end
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the number of consecutive opposite samples seen so far; any
  // state change clears it, so an interrupted candidate restarts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      LO: if (s) begin
        if (FILT_CYCLES == 1) state_nxt = HI;
        else begin
          state_nxt = QRISE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      QRISE: if (!s) begin
        state_nxt = LO;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nxt = HI;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 1'b1;
      HI: if (!s) begin
        if (FILT_CYCLES == 1) state_nxt = LO;
        else begin
          state_nxt = QFALL;
          cnt_nxt   = CNT_W'(1);
        end
      end
      QFALL: if (s) begin
        state_nxt = HI;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nxt = LO;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt + 1'b1;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    z_nxt    = (state_nxt == HI) || (state_nxt == QFALL);
    busy_nxt = (state_nxt == QRISE) || (state_nxt == QFALL);
    rise_nxt = z_nxt && !Z;
    fall_nxt = !z_nxt && Z;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Z    <= 1'b0;
      RISE <= 1'b0;
      FALL <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      Z    <= z_nxt;
      RISE <= rise_nxt;
      FALL <= fall_nxt;
      BUSY <= busy_nxt;
    end
  end

`ifdef DLY_DEGLITCH_EVT_CNT_EN
  logic [7:0] evt_q;
  // Counts on the same edge that raises RISE/FALL; saturates at 255.
  always_ff @(posedge CLK) begin
    if (RST) evt_q <= '0;
    else if ((rise_nxt || fall_nxt) && evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
  end
  assign EVT_CNT = evt_q;
`else
  assign EVT_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_dly_deglitch_filter.sv
// Randomised and directed bench for dly_deglitch_filter: a default instance and a
// FILT_CYCLES=1 / SYNC_STAGES=3 instance, both checked every cycle against a run-length model.
module tb_dly_deglitch_filter;
  localparam int SS0 = 2, F0 = 4;
  localparam int SS1 = 3, F1 = 1;
`ifdef DLY_DEGLITCH_EVT_CNT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, i_in = 1'b0;
  logic z0, rise0, fall0, busy0, z1, rise1, fall1, busy1;
  logic [7:0] evt0, evt1;
  int n_vec = 0, n_err = 0;

  dly_deglitch_filter #(.SYNC_STAGES(SS0), .FILT_CYCLES(F0), .CNT_W(8)) dut0 (
    .CLK(clk), .RST(rst), .I(i_in), .Z(z0), .RISE(rise0), .FALL(fall0),
    .BUSY(busy0), .EVT_CNT(evt0));
  dly_deglitch_filter #(.SYNC_STAGES(SS1), .FILT_CYCLES(F1), .CNT_W(8)) dut1 (
    .CLK(clk), .RST(rst), .I(i_in), .Z(z1), .RISE(rise1), .FALL(fall1),
    .BUSY(busy1), .EVT_CNT(evt1));

  always #5 clk = ~clk;

  // Model: I is delayed SYNC samples to s; Z flips once s has differed from Z
  // for FILT consecutive samples, otherwise the run length starts over.
  bit [3:0] m_sh[2];
  bit       m_z[2], m_rise[2], m_fall[2];
  int       m_run[2], m_evt[2];

  task automatic model_step(input int d, input int ss, input int f);
    bit s;
    if (rst) begin
      m_sh[d] = '0; m_z[d] = 0; m_run[d] = 0; m_rise[d] = 0; m_fall[d] = 0; m_evt[d] = 0;
    end else begin
      s = m_sh[d][ss-1];
      m_sh[d] = {m_sh[d][2:0], i_in};
      m_rise[d] = 0; m_fall[d] = 0;
      if (s != m_z[d]) begin
        m_run[d]++;
        if (m_run[d] == f) begin
          m_z[d] = s; m_run[d] = 0;
          m_rise[d] = s; m_fall[d] = !s;
          if (EVT_ON && m_evt[d] < 255) m_evt[d]++;
        end
      end else m_run[d] = 0;
    end
  endtask

  function automatic logic [11:0] exp_vec(input int d);
    return {m_z[d], m_rise[d], m_fall[d], m_run[d] > 0, 8'(m_evt[d])};
  endfunction

  wire [11:0] obs0 = {z0, rise0, fall0, busy0, evt0};
  wire [11:0] obs1 = {z1, rise1, fall1, busy1, evt1};

  task automatic tick();
    @(posedge clk);
    model_step(0, SS0, F0);
    model_step(1, SS1, F1);
    #1;
  endtask

  task automatic idle(input int n, input bit lvl);
    i_in = lvl;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    i_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rst = (k == 3);
      tick();
      n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL reset dut0 edge %0d: got %h want %h", k, obs0, exp_vec(0)); end
      n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL reset dut1 edge %0d: got %h want %h", k, obs1, exp_vec(1)); end
      if (k == 3) begin
        n_vec++; if (z0 !== 1'b0 || busy0 !== 1'b0 || evt0 !== 8'd0) begin n_err++; $display("FAIL reset_clear: z=%b busy=%b evt=%0d want 0 0 0", z0, busy0, evt0); end
      end
      if (k == 8) begin
        n_vec++; if (z0 !== 1'b0 || rise0 !== 1'b0) begin n_err++; $display("FAIL reset_requal_early: z=%b rise=%b want 0 0", z0, rise0); end
      end
      if (k == 9) begin
        n_vec++; if (z0 !== 1'b1 || rise0 !== 1'b1) begin n_err++; $display("FAIL reset_requal: z=%b rise=%b want 1 1", z0, rise0); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_rise();
    apply_reset(); idle(6, 1'b0);
    i_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL clean_rise dut0 edge %0d: got %h want %h", k, obs0, exp_vec(0)); end
      n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL clean_rise dut1 edge %0d: got %h want %h", k, obs1, exp_vec(1)); end
      n_vec++;
      if (z0 !== (k >= 5) || rise0 !== (k == 5) || busy0 !== (k >= 2 && k <= 4)) begin
        n_err++; $display("FAIL clean_rise_timing edge %0d: z=%b rise=%b busy=%b", k, z0, rise0, busy0);
      end
    end
  endtask

  task automatic test_runt();
    bit seen_busy = 0, bad = 0;
    apply_reset(); idle(6, 1'b0);
    for (int k = 0; k < 14; k++) begin
      i_in = (k < 3);
      tick();
      n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL runt dut0 edge %0d: got %h want %h", k, obs0, exp_vec(0)); end
      n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL runt dut1 edge %0d: got %h want %h", k, obs1, exp_vec(1)); end
      if (busy0) seen_busy = 1;
      if (z0 || rise0 || fall0) bad = 1;
    end
    n_vec++; if (bad || !seen_busy || busy0 !== 1'b0) begin n_err++; $display("FAIL runt_suppress: leaked=%b busy_seen=%b busy_end=%b want 0 1 0", bad, seen_busy, busy0); end
  endtask

  task automatic test_interrupted_fall();
    int falls = 0, fall_at = -1;
    idle(12, 1'b1);
    for (int k = 0; k < 14; k++) begin
      i_in = (k == 2);
      tick();
      n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL int_fall dut0 edge %0d: got %h want %h", k, obs0, exp_vec(0)); end
      n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL int_fall dut1 edge %0d: got %h want %h", k, obs1, exp_vec(1)); end
      if (fall0) begin falls++; fall_at = k; end
      if (k < 8 && z0 !== 1'b1) begin n_vec++; n_err++; $display("FAIL int_fall_early edge %0d: z=%b want 1", k, z0); end
    end
    n_vec++; if (falls != 1 || fall_at != 8 || z0 !== 1'b0) begin n_err++; $display("FAIL int_fall_strobe: count=%0d at=%0d z=%b want 1 8 0", falls, fall_at, z0); end
  endtask

  task automatic test_filt1();
    bit ih[64];
    apply_reset(); idle(6, 1'b0);
    for (int k = 0; k < 40; k++) begin
      i_in = ((k / 4) % 2) == 1;
      ih[k] = i_in;
      tick();
      n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL filt1 dut1 edge %0d: got %h want %h", k, obs1, exp_vec(1)); end
      n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL filt1 dut0 edge %0d: got %h want %h", k, obs0, exp_vec(0)); end
      if (k >= SS1) begin
        n_vec++; if (z1 !== ih[k-SS1] || busy1 !== 1'b0) begin n_err++; $display("FAIL filt1_follow edge %0d: z=%b busy=%b want %b 0", k, z1, busy1, ih[k-SS1]); end
      end
    end
  endtask

  task automatic test_random();
    int left = 0;
    for (int k = 0; k < 600; k++) begin
      if (left == 0) begin i_in = $urandom_range(1, 0); left = $urandom_range(7, 1); end
      left--;
      rst = ($urandom_range(59, 0) == 0);
      tick();
      n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL random dut0 cyc %0d: got %h want %h", k, obs0, exp_vec(0)); end
      n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL random dut1 cyc %0d: got %h want %h", k, obs1, exp_vec(1)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_evt_cnt();
    logic [7:0] want;
    want = EVT_ON ? 8'd255 : 8'd0;
    apply_reset(); idle(6, 1'b0);
    for (int t = 0; t < 300; t++) begin
      i_in = ~i_in;
      for (int c = 0; c < 6; c++) begin
        tick();
        n_vec++; if (obs0 !== exp_vec(0)) begin n_err++; $display("FAIL evt dut0 tr %0d: got %h want %h", t, obs0, exp_vec(0)); end
        n_vec++; if (obs1 !== exp_vec(1)) begin n_err++; $display("FAIL evt dut1 tr %0d: got %h want %h", t, obs1, exp_vec(1)); end
      end
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_vec++; if (evt0 !== want || evt1 !== want) begin n_err++; $display("FAIL evt_sat: evt0=%0d evt1=%0d want %0d", evt0, evt1, want); end
    end
  endtask

  initial begin
    rst = 1'b1; i_in = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    idle(4, 1'b0);
    test_reset();
    test_clean_rise();
    test_runt();
    test_interrupted_fall();
    test_filt1();
    test_random();
    test_evt_cnt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dly_deglitch_filter.md
Name: dly_deglitch_filter

Overview:
- Synchronous qualifier that sits directly downstream of a delay-cell chain.
- Synchronises the asynchronous delayed signal I into the CLK domain.
- Passes a level change to Z only after it has been stable for FILT_CYCLES consecutive samples, so glitches and runt pulses from the chain are suppressed.
- Emits single-cycle edge strobes for downstream control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on I; legal range 2..4.
- FILT_CYCLES, 4, consecutive equal samples required to accept a level change; legal range 1..255.
- CNT_W, 8, qualification counter width; elaboration error unless FILT_CYCLES < 2**CNT_W.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  reset; synchronous, active-high.
- I  input  1  asynchronous delayed signal from the delay chain.
- Z  output  1  filtered, synchronised level.
- RISE  output  1  one-cycle strobe, high in the same cycle Z goes 0->1.
- FALL  output  1  one-cycle strobe, high in the same cycle Z goes 1->0.
- BUSY  output  1  high while a candidate transition is being qualified.
- EVT_CNT  output  8  count of accepted transitions; see Optional Feature.

Behaviour:
- Reset:
  - Takes effect on the CLK edge where RST=1.
  - Clears all synchroniser flops, counter, state (LO), Z, RISE, FALL, BUSY and EVT_CNT to 0.
  - Applies mid-qualification too: any in-progress count is discarded, and Z=0 even if I is high.
  - After reset deasserts, a high I must be requalified from scratch.
- Synchroniser:
  - I feeds a SYNC_STAGES-deep flop chain; the final stage is s.
  - The FSM uses only s.
- FSM states: LO, QRISE, HI, QFALL.
  - LO: s=0 stays. s=1: if FILT_CYCLES=1, go HI; else go QRISE with cnt=1.
  - QRISE: s=0 aborts to LO with cnt=0; Z stays 0, no strobe. s=1: if cnt+1=FILT_CYCLES, go HI; else cnt++.
  - HI: symmetric to LO with s=0 leading to QFALL.
  - QFALL: symmetric to QRISE, ending in LO.
- Outputs:
  - Z=1 exactly in state HI and QFALL; Z=0 in LO and QRISE. Z is registered.
  - RISE is high for one cycle on the LO/QRISE->HI transition. FALL is high for one cycle on the HI/QFALL->LO transition. Never both high.
  - BUSY is registered, =1 in QRISE and QFALL.
- Latency:
  - I changes before edge 0; Z changes after edge SYNC_STAGES+FILT_CYCLES-1.
  - Defaults: Z updates after edge 5.
- Glitches:
  - Any pulse on s shorter than FILT_CYCLES samples leaves Z, RISE and FALL unchanged.
  - A single opposite sample restarts qualification; there is no accumulation across interruptions.
- Counter:
  - cnt is unsigned, CNT_W bits, cleared on every state change.
  - cnt never exceeds FILT_CYCLES-1, so it cannot wrap.
- Metastability: the output depends only on s; no combinational path from I to any output.

Optional Feature:
- Macro: DLY_DEGLITCH_EVT_CNT_EN.
- Defined:
  - EVT_CNT is an 8-bit saturating counter, incremented in the cycle RISE or FALL is high.
  - It holds at 255 and is cleared by RST.
- Undefined:
  - The counter logic is not built and EVT_CNT is tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset mid-qualification:
  - Stimulus: defaults, I=1 held from before edge 0; RST=1 at edge 3, released at edge 4.
  - Required: Z=0, BUSY=0 after edge 3; Z=1 and RISE=1 only after edge 9 (requalified from edge 4).
- Clean rise:
  - Stimulus: defaults, I 0->1 before edge 0, held.
  - Required: Z=1 and RISE=1 after edge 5; RISE=0 after edge 6; BUSY=1 after edges 2-4.
- Runt pulse:
  - Stimulus: I high for 3 cycles then low, FILT_CYCLES=4.
  - Required: Z stays 0, no RISE; BUSY pulses and returns to 0.
- Interrupted fall:
  - Stimulus: Z=1; I low 2 cycles, high 1 cycle, then low held.
  - Required: no FALL until 4 consecutive low samples after the last interruption; FALL exactly one cycle.
- FILT_CYCLES=1 build:
  - Stimulus: I toggled every 4 cycles.
  - Required: Z follows I with latency SYNC_STAGES; BUSY never asserts.
- Event counter (macro on):
  - Stimulus: 300 qualified transitions.
  - Required: EVT_CNT=255 and holds.
  - Macro off: EVT_CNT=0 throughout.
